// File: rtl/multdiv_ctrl.sv
// Sequencing controller for the iterative multiply/divide unit: issues one op,
// waits for its result (or a watchdog timeout), and arbitrates the writeback port.
module multdiv_ctrl #(
  parameter int unsigned TIMEOUT  = 40,
  parameter logic [31:0] EXC_MULT = 32'd4,
  parameter logic [31:0] EXC_DIV  = 32'd5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic        issue_is_div,
  input  logic [4:0]  issue_rd,
  input  logic [31:0] issue_opA,
  input  logic [31:0] issue_opB,
  input  logic [4:0]  dec_srcA,
  input  logic [4:0]  dec_srcB,
  output logic        stall,
  output logic        md_ctrl_MULT,
  output logic        md_ctrl_DIV,
  output logic [31:0] md_opA,
  output logic [31:0] md_opB,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  input  logic        alu_wb_valid,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        busy,
  output logic [4:0]  busy_rd
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_WB    = 2'd3;

  localparam logic [4:0]  EXC_REG  = 5'd30;
  localparam int unsigned CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          is_div;
  logic [4:0]    rd_q;
  logic [31:0]   res_q;
  logic          exc_q;
  logic          in_wb;
  logic          hazard;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      rd_q   <= '0;
      res_q  <= '0;
      exc_q  <= 1'b0;
      md_opA <= '0;
      md_opB <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (issue_valid) begin
            state  <= S_START;
            is_div <= issue_is_div;
            rd_q   <= issue_rd;
            md_opA <= issue_opA;
            md_opB <= issue_opB;
            res_q  <= '0;
            exc_q  <= 1'b0;
          end
        end
        S_START: state <= S_WAIT;
        S_WAIT: begin
          // A result arriving on the final watchdog cycle still wins over the timeout.
          if (md_resultRDY) begin
            res_q <= md_result;
            exc_q <= md_exception;
            state <= S_WB;
          end else if (cnt == CNT_LAST) begin
            exc_q <= 1'b1;
            state <= S_WB;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WB: begin
          if (!alu_wb_valid) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy         = (state != S_IDLE);
    busy_rd      = busy ? rd_q : '0;
    hazard       = busy && (rd_q != '0) && ((dec_srcA == rd_q) || (dec_srcB == rd_q));
    stall        = (busy && issue_valid) || hazard;
    md_ctrl_MULT = (state == S_START) && !is_div;
    md_ctrl_DIV  = (state == S_START) && is_div;
    in_wb        = (state == S_WB);
    // A clean result for r0 retires through WB without touching the port.
    wb_en        = in_wb && !alu_wb_valid && (exc_q || (rd_q != '0));
    wb_rd        = '0;
    wb_data      = '0;
    if (in_wb) begin
      wb_rd   = exc_q ? EXC_REG : rd_q;
      wb_data = exc_q ? (is_div ? EXC_DIV : EXC_MULT) : res_q;
    end
  end

endmodule
